// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter sharing one registered GPR write port among NREQ writeback sources.
// Optional GPR_WB_TRACE_EN: simulation-only print of every committed GPR write.
module gpr_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int SCW  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               gpr_we,
  output logic [AW-1:0]      gpr_a3,
  output logic [DW-1:0]      gpr_wd,
  output logic [SCW-1:0]     stall_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr_reg;
  logic [PW-1:0]   rr_ptr_next;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            grant_found;
  logic            accept;
  logic            multi_req;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            gpr_we_reg;
  logic [AW-1:0]   gpr_a3_reg;
  logic [DW-1:0]   gpr_wd_reg;
  logic [SCW-1:0]  stall_cnt_reg;
  int              scan_idx;
  int              valid_cnt;

  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
      assign data_arr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // Scan upward from rr_ptr, wrapping at NREQ; first valid requester wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(rr_ptr_reg) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found      = 1'b1;
        grant[scan_idx]  = 1'b1;
        grant_idx        = PW'(scan_idx);
      end
    end
  end

  always_comb begin
    valid_cnt = 0;
    for (int k = 0; k < NREQ; k++) valid_cnt = valid_cnt + int'(req_valid[k]);
    multi_req = (valid_cnt >= 2);
  end

  assign req_ready   = reset ? '0 : grant;
  assign accept      = grant_found && !reset;
  assign sel_addr    = addr_arr[grant_idx];
  assign sel_data    = data_arr[grant_idx];
  assign rr_ptr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg    <= '0;
      gpr_we_reg    <= 1'b0;
      gpr_a3_reg    <= '0;
      gpr_wd_reg    <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (accept) begin
        rr_ptr_reg <= rr_ptr_next;
        // $0 is hardwired: the write is consumed but never enabled.
        gpr_we_reg <= (sel_addr != '0);
        gpr_a3_reg <= sel_addr;
        gpr_wd_reg <= sel_data;
      end else begin
        gpr_we_reg <= 1'b0;
      end
      if (multi_req && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign gpr_we    = gpr_we_reg;
  assign gpr_a3    = gpr_a3_reg;
  assign gpr_wd    = gpr_wd_reg;
  assign stall_cnt = stall_cnt_reg;

`ifdef GPR_WB_TRACE_EN
  logic [PW-1:0] trace_g_reg;

  always_ff @(posedge clk) begin
    if (reset) trace_g_reg <= '0;
    else if (accept) trace_g_reg <= grant_idx;
    if (!reset && gpr_we_reg)
      $display("$%0d <= %h (req %0d)", gpr_a3_reg, gpr_wd_reg, trace_g_reg);
  end
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed steps then random traffic against a reference model.
module tb_gpr_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               gpr_we;
  logic [AW-1:0]      gpr_a3;
  logic [DW-1:0]      gpr_wd;
  logic [15:0]        stall_cnt;

  logic [NREQ-1:0]    req_ready4;
  logic               gpr_we4;
  logic [AW-1:0]      gpr_a34;
  logic [DW-1:0]      gpr_wd4;
  logic [3:0]         stall_cnt4;

  gpr_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SCW(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .gpr_we(gpr_we),
    .gpr_a3(gpr_a3), .gpr_wd(gpr_wd), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance on the same stimulus exercises saturation.
  gpr_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SCW(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready4), .gpr_we(gpr_we4),
    .gpr_a3(gpr_a34), .gpr_wd(gpr_wd4), .stall_cnt(stall_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  int          m_stall;
  int          m_stall4;
  logic [2:0]  last_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [2:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // One clock: check grant before the edge, advance model, check registered outputs after.
  task automatic cycle();
    int          g;
    logic [2:0]  exp_ready;
    logic        r;
    logic [4:0]  a;
    logic [31:0] d;
    logic [2:0]  v;
    #1;
    r = reset;
    v = req_valid;
    g = model_grant(v, m_ptr);
    exp_ready = (r || g < 0) ? 3'b000 : (3'b001 << g);
    a = (g >= 0) ? req_addr[g*AW +: AW] : 5'd0;
    d = (g >= 0) ? req_data[g*DW +: DW] : 32'd0;
    last_ready = req_ready;
    check("req_ready", {61'd0, req_ready}, {61'd0, exp_ready});
    check("req_ready4", {61'd0, req_ready4}, {61'd0, exp_ready});
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_we = 1'b0; m_a3 = '0; m_wd = '0; m_stall = 0; m_stall4 = 0;
    end else begin
      if (g >= 0) begin
        m_we  = (a != 5'd0);
        m_a3  = a;
        m_wd  = d;
        m_ptr = (g + 1) % NREQ;
      end else begin
        m_we = 1'b0;
      end
      if ($countones(v) >= 2) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
    end
    #1;
    check("gpr_we", {63'd0, gpr_we}, {63'd0, m_we});
    check("gpr_a3", {59'd0, gpr_a3}, {59'd0, m_a3});
    check("gpr_wd", {32'd0, gpr_wd}, {32'd0, m_wd});
    check("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
    check("stall_cnt4", {60'd0, stall_cnt4}, 64'(m_stall4));
    check("gpr_we4", {63'd0, gpr_we4}, {63'd0, m_we});
  endtask

  initial begin
    int s0;
    m_ptr = 0; m_we = 0; m_a3 = 0; m_wd = 0; m_stall = 0; m_stall4 = 0;
    reset = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0;

    // Reset with all requesters active: ready must stay low.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 3), 32'hA000_0000 + 32'(i));
    repeat (3) cycle();
    check("rst_we", {63'd0, gpr_we}, 64'd0);
    check("rst_stall", {48'd0, stall_cnt}, 64'd0);

    reset = 1'b0;
    req_valid = '0;
    repeat (2) cycle();
    check("idle_we", {63'd0, gpr_we}, 64'd0);

    // Single requester 1
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle();
    check("single_ready", {61'd0, last_ready}, 64'b010);
    check("single_we", {63'd0, gpr_we}, 64'd1);
    check("single_a3", {59'd0, gpr_a3}, 64'd5);
    check("single_wd", {32'd0, gpr_wd}, 64'hDEADBEEF);
    req_valid = '0;

    // Requester 2 alone moves the pointer back to 0
    set_req(2, 1'b1, 5'd7, 32'h0000_0777);
    cycle();
    check("ptr2_ready", {61'd0, last_ready}, 64'b100);
    req_valid = '0;

    // All three continuously valid: grants 0,1,2,0
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 10), 32'hC0DE_0000 + 32'(i));
    for (int n = 0; n < 4; n++) begin
      cycle();
      check("rr_ready", {61'd0, last_ready}, 64'(3'b001 << (n % 3)));
      check("rr_we", {63'd0, gpr_we}, 64'd1);
    end
    req_valid = '0;
    cycle();

    // Write to $0 from requester 0 (pointer is 1 here; make it 0 first)
    set_req(2, 1'b1, 5'd3, 32'h3);
    cycle();
    req_valid = '0;
    set_req(0, 1'b1, 5'd0, 32'h12345678);
    cycle();
    check("zero_ready", {61'd0, last_ready}, 64'b001);
    check("zero_we", {63'd0, gpr_we}, 64'd0);
    req_valid = '0;
    set_req(1, 1'b1, 5'd4, 32'h4);
    set_req(2, 1'b1, 5'd6, 32'h6);
    cycle();
    check("zero_ptr_adv", {61'd0, last_ready}, 64'b010);
    req_valid = '0;

    // Collision on $9 with pointer at 2
    s0 = m_stall;
    set_req(0, 1'b1, 5'd9, 32'h1);
    set_req(2, 1'b1, 5'd9, 32'h2);
    cycle();
    check("coll_first", {61'd0, last_ready}, 64'b100);
    check("coll_wd2", {32'd0, gpr_wd}, 64'h2);
    req_valid[2] = 1'b0;
    cycle();
    check("coll_second", {61'd0, last_ready}, 64'b001);
    check("coll_wd1", {32'd0, gpr_wd}, 64'h1);
    check("coll_stall", {48'd0, stall_cnt}, 64'(s0 + 1));
    req_valid = '0;

    // Reset coinciding with a request from requester 1
    set_req(1, 1'b1, 5'd8, 32'h88);
    reset = 1'b1;
    cycle();
    check("midrst_we", {63'd0, gpr_we}, 64'd0);
    check("midrst_stall", {48'd0, stall_cnt}, 64'd0);
    reset = 1'b0;
    req_valid = '0;
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    cycle();
    check("midrst_ptr0", {61'd0, last_ready}, 64'b001);

    // Two requesters held for 20 cycles: narrow counter pins at 15
    repeat (20) cycle();
    check("sat4", {60'd0, stall_cnt4}, 64'd15);
    req_valid = '0;
    cycle();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                32'($urandom));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
